// File: rtl/onehot_decoder_tree.sv
// Binary-to-one-hot decoder built as a tree of small enable-gated leaf decoders,
// with a combinational output and a one-cycle registered copy plus valid flag.

module onehot_dec_leaf #(
    parameter int W = 1
) (
    input  logic              enable,
    input  logic [W-1:0]      in,
    output logic [(1<<W)-1:0] out
);

    always_comb begin
        out = '0;
        for (int k = 0; k < (1 << W); k++) begin
            out[k] = enable && (in == W'(k));
        end
    end

endmodule

module onehot_decoder_tree #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 2**IN_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out_comb,
    output logic [OUT_W-1:0] out,
    output logic             valid
);

    logic [OUT_W-1:0] out_d, out_q;
    logic             valid_d, valid_q;

    generate
        if (IN_W == 3) begin : g_w3
            logic [1:0] leaf_en;
            onehot_dec_leaf #(.W(1)) u_up (
                .enable (enable),
                .in     (in[2]),
                .out    (leaf_en)
            );
            for (genvar k = 0; k < 2; k++) begin : g_leaf
                onehot_dec_leaf #(.W(2)) u_leaf (
                    .enable (leaf_en[k]),
                    .in     (in[1:0]),
                    .out    (out_comb[4*k+3:4*k])
                );
            end
        end else if (IN_W > 4) begin : g_wide
            // Upper bits select which 4-to-16 leaf is enabled.
            localparam int UP_W = IN_W - 4;
            logic [(1<<UP_W)-1:0] leaf_en;
            onehot_dec_leaf #(.W(UP_W)) u_up (
                .enable (enable),
                .in     (in[IN_W-1:4]),
                .out    (leaf_en)
            );
            for (genvar k = 0; k < (1 << UP_W); k++) begin : g_leaf
                onehot_dec_leaf #(.W(4)) u_leaf (
                    .enable (leaf_en[k]),
                    .in     (in[3:0]),
                    .out    (out_comb[16*k+15:16*k])
                );
            end
        end else begin : g_single
            onehot_dec_leaf #(.W(IN_W)) u_leaf (
                .enable (enable),
                .in     (in),
                .out    (out_comb)
            );
        end
    endgenerate

    always_comb begin
        out_d   = '0;
        valid_d = 1'b0;
        if (reset_n) begin
            out_d   = out_comb;
            valid_d = enable;
        end
    end

    always_ff @(posedge clk) begin
        out_q   <= out_d;
        valid_q <= valid_d;
    end

    assign out   = out_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_onehot_decoder_tree.sv
// Scoreboard bench: one decoder instance per width 1..6, each with its own
// stimulus process, expected-value queue and monitor against a one-hot model.

module tb_onehot_decoder_tree;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec      = 0;
    int miscompares = 0;
    int done_cnt   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hand-written spot values; zero means "no spot check for this code".
    function automatic logic [63:0] spot_exp(input int w, input int s);
        logic [63:0] r;
        r = 64'd0;
        case (w)
            1: if (s == 1)  r = 64'h2;
            2: if (s == 2)  r = 64'h4;
            3: if (s == 5)  r = 64'h20;
            4: if (s == 9)  r = 64'h200;
            5: begin
                if (s == 0)  r = 64'h1;
                if (s == 16) r = 64'h0001_0000;
                if (s == 31) r = 64'h8000_0000;
            end
            6: if (s == 63) r = 64'h8000_0000_0000_0000;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    for (genvar g = 1; g <= 6; g++) begin : gw
        localparam int OW = 1 << g;

        logic          rn;
        logic          en;
        logic [g-1:0]  sel;
        logic [OW-1:0] oc;
        logic [OW-1:0] oq;
        logic          v;
        logic [64:0]   q[$];

        onehot_decoder_tree #(.IN_W(g)) dut (
            .clk      (clk),
            .reset_n  (rn),
            .enable   (en),
            .in       (sel),
            .out_comb (oc),
            .out      (oq),
            .valid    (v)
        );

        task automatic step(input bit r, input bit e, input int s);
            logic [63:0] exp_c;
            logic [63:0] sp;
            @(negedge clk);
            rn  = r;
            en  = e;
            sel = s[g-1:0];
            #1;
            exp_c = e ? (64'd1 << s) : 64'd0;
            chk($sformatf("w%0d comb en=%0d in=%0d", g, e, s), 64'(oc), exp_c);
            if (e) chk($sformatf("w%0d comb onehot in=%0d", g, s), 64'($countones(oc)), 64'd1);
            sp = spot_exp(g, s);
            if (e && sp != 64'd0) chk($sformatf("w%0d spot in=%0d", g, s), 64'(oc), sp);
            q.push_back({r ? e : 1'b0, r ? exp_c : 64'd0});
        endtask

        initial begin
            logic [64:0] e;
            forever begin
                @(posedge clk);
                #1;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk($sformatf("w%0d reg out", g), 64'(oq), e[63:0]);
                    chk($sformatf("w%0d reg valid", g), 64'(v), 64'(e[64]));
                    chk($sformatf("w%0d reg invariant", g),
                        64'(v ? ($countones(oq) == 1) : (oq == '0)), 64'd1);
                end
            end
        end

        initial begin
            step(1'b0, 1'b1, 7 % OW);
            step(1'b0, 1'b1, 7 % OW);
            step(1'b1, 1'b1, 7 % OW);
            for (int s = 0; s < OW; s++) step(1'b1, 1'b1, s);
            for (int s = 0; s < OW; s++) step(1'b1, 1'b0, s);
            for (int i = 0; i < 8; i++) step(1'b1, (i % 2) == 0, 20 % OW);
            for (int i = 0; i < 200; i++)
                step($urandom_range(0, 15) != 0, 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, OW - 1)));
            repeat (3) @(negedge clk);
            chk($sformatf("w%0d queue drained", g), 64'(q.size()), 64'd0);
            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 5000 && done_cnt < 6; i++) @(posedge clk);
        if (done_cnt < 6) begin
            miscompares++;
            $display("FAIL timeout: done %0d of 6", done_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule
